mips_mem_arbiter: RTL and testbench
===================================

// Module: mips_mem_arbiter
// PURPOSE
//  Shares one single-port memory between the CPU instruction-fetch and data ports for a
//  unified-memory build of the MIPS core. Arbitrates per access, issues memory strobes,
//  counts read latency, returns read data to the winner. Stalls the loser via waitrequest.
// PARAMETERS
//  READ_LATENCY  1  cycles from read-issue edge to mem_readdata valid; legal 1..4
// PORTS
//  clk               in   1   system clock, rising edge
//  reset             in   1   asynchronous, active-low reset
//  clk_enable        in   1   global enable; low = freeze all state, no grants
//  instr_req         in   1   fetch request; held until accepted
//  instr_address     in   32  fetch address
//  instr_waitrequest out  1   1 = fetch not accepted this cycle
//  instr_rvalid      out  1   one-cycle pulse: instr_readdata valid
//  instr_readdata    out  32  fetched word, held until next fetch return
//  data_read         in   1   data read request
//  data_write        in   1   data write request (wins if both set; read dropped)
//  data_address      in   32  data address
//  data_writedata    in   32  store data
//  data_waitrequest  out  1   1 = data access not accepted this cycle
//  data_rvalid       out  1   one-cycle pulse: data_readdata valid
//  data_readdata     out  32  loaded word, held until next load return
//  mem_address       out  32  memory address
//  mem_read          out  1   one-cycle read strobe
//  mem_write         out  1   one-cycle write strobe
//  mem_writedata     out  32  memory write data
//  mem_readdata      in   32  memory read data
// BEHAVIOUR
//  States: IDLE, RD_WAIT. Registers: state, owner, lat_cnt, rr_ptr, *_readdata, *_rvalid.
//  Reset (low): state=IDLE, rr_ptr=DATA, rvalid=0, readdata=0; while low, both
//   waitrequest=1, mem_read=mem_write=0, mem_address/mem_writedata=0. Reset mid-read
//   aborts it: no rvalid ever for that access.
//  IDLE, clk_enable=1: requesters = {data_read|data_write, instr_req}. One requester ->
//   it wins. Both -> rr_ptr wins. Winner's address/data drive mem_* combinationally,
//   winner waitrequest=0 (accepted at this edge), loser waitrequest=1. No request ->
//   both waitrequest=0? No: both=1, strobes 0.
//  Accepted write: mem_write=1 this cycle; state stays IDLE; rr_ptr flips to other port.
//  Accepted read: mem_read=1 this cycle; next state RD_WAIT, owner=winner,
//   lat_cnt=READ_LATENCY-1; rr_ptr flips.
//  RD_WAIT: strobes 0, both waitrequest=1. lat_cnt decrements each enabled cycle; on the
//   edge ending the cycle with lat_cnt==0, mem_readdata -> owner_readdata, owner_rvalid=1
//   for next cycle only, state->IDLE (new grant legal in the rvalid cycle).
//  Timing: issue cycle 0 -> rvalid cycle READ_LATENCY+1; write throughput 1/cycle.
//  clk_enable=0: all registers hold, both waitrequest=1, strobes 0; rvalid holds value.
//  Requester may drop req before acceptance; no access recorded.
//  data_read&data_write: treated as write only.
// TESTING
//  1 reset low, both ports requesting -> waitrequests 1, mem_read/mem_write 0, rvalid 0.
//  2 L=1, fetch 0xBFC00000, mem returns 0x24840003 -> mem_read+addr cycle0,
//    instr_rvalid=1, instr_readdata=0x24840003 in cycle 2, pulse one cycle.
//  3 After reset, data write (0x10,7) and fetch together -> data granted cycle0
//    (mem_write, data 7), fetch granted cycle1; repeated contention alternates.
//  4 L=2, back-to-back data reads -> issue cycles 0 and 3, data_rvalid at 3 and 6.
//  5 reset pulsed low during RD_WAIT -> no rvalid; first request after release granted.
//  6 clk_enable low 3 cycles inside RD_WAIT (L=1) -> rvalid at cycle 5, data correct.

Source files
------------

// File: rtl/mips_mem_arbiter.sv
// Shares one single-port memory between the MIPS instruction-fetch and data ports.
// Per-access round-robin arbitration, read-latency counting and read-data return to the winner.
module mips_mem_arbiter #(
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,

    input  logic        instr_req,
    input  logic [31:0] instr_address,
    output logic        instr_waitrequest,
    output logic        instr_rvalid,
    output logic [31:0] instr_readdata,

    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_address,
    input  logic [31:0] data_writedata,
    output logic        data_waitrequest,
    output logic        data_rvalid,
    output logic [31:0] data_readdata,

    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata
);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] RD_WAIT = 1'b1;

    localparam logic PORT_INSTR = 1'b0;
    localparam logic PORT_DATA  = 1'b1;

    localparam logic [1:0] LAT_INIT = 2'(READ_LATENCY - 1);

    logic [0:0] state;
    logic       owner;
    logic       rr_ptr;
    logic [1:0] lat_cnt;

    logic data_req;
    logic can_grant;
    logic grant_data;
    logic grant_instr;
    logic grant_read;

    // Arbitration is combinational so the winner's strobe issues in the request cycle.
    always_comb begin
        data_req    = data_read | data_write;
        can_grant   = reset & clk_enable & (state == IDLE);
        grant_data  = can_grant & data_req & (~instr_req | (rr_ptr == PORT_DATA));
        grant_instr = can_grant & instr_req & ~grant_data;
        grant_read  = grant_instr | (grant_data & ~data_write);
    end

    always_comb begin
        instr_waitrequest = ~grant_instr;
        data_waitrequest  = ~grant_data;
        mem_read          = grant_read;
        mem_write         = grant_data & data_write;
        mem_address       = 32'h0;
        mem_writedata     = 32'h0;
        if (grant_data) begin
            mem_address = data_address;
            if (data_write) begin
                mem_writedata = data_writedata;
            end
        end else if (grant_instr) begin
            mem_address = instr_address;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            owner          <= PORT_INSTR;
            rr_ptr         <= PORT_DATA;
            lat_cnt        <= 2'd0;
            instr_rvalid   <= 1'b0;
            data_rvalid    <= 1'b0;
            instr_readdata <= 32'h0;
            data_readdata  <= 32'h0;
        end else if (clk_enable) begin
            instr_rvalid <= 1'b0;
            data_rvalid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_data || grant_instr) begin
                        rr_ptr <= grant_data ? PORT_INSTR : PORT_DATA;
                    end
                    if (grant_read) begin
                        state   <= RD_WAIT;
                        owner   <= grant_data ? PORT_DATA : PORT_INSTR;
                        lat_cnt <= LAT_INIT;
                    end
                end
                RD_WAIT: begin
                    // Memory data is valid in the cycle where the countdown reaches zero.
                    if (lat_cnt == 2'd0) begin
                        state <= IDLE;
                        if (owner == PORT_DATA) begin
                            data_readdata <= mem_readdata;
                            data_rvalid   <= 1'b1;
                        end else begin
                            instr_readdata <= mem_readdata;
                            instr_rvalid   <= 1'b1;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter: one instance at READ_LATENCY=1 (a) and one at 2 (b),
// both driven from the same request inputs, each with its own memory model.
module tb_mips_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clk_enable = 1'b1;
    logic        instr_req = 1'b0;
    logic [31:0] instr_address = 32'h0;
    logic        data_read = 1'b0;
    logic        data_write = 1'b0;
    logic [31:0] data_address = 32'h0;
    logic [31:0] data_writedata = 32'h0;

    logic        instr_waitrequest_a, instr_rvalid_a, data_waitrequest_a, data_rvalid_a;
    logic        mem_read_a, mem_write_a;
    logic [31:0] instr_readdata_a, data_readdata_a, mem_address_a, mem_writedata_a;
    logic [31:0] mem_readdata_a = 32'h0;

    logic        instr_waitrequest_b, instr_rvalid_b, data_waitrequest_b, data_rvalid_b;
    logic        mem_read_b, mem_write_b;
    logic [31:0] instr_readdata_b, data_readdata_b, mem_address_b, mem_writedata_b;
    logic [31:0] mem_readdata_b = 32'h0;
    logic [31:0] pend_data_b = 32'h0;
    logic        pend_b = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mips_mem_arbiter #(.READ_LATENCY(1)) dut_a (
        .clk(clk), .reset(reset), .clk_enable(clk_enable),
        .instr_req(instr_req), .instr_address(instr_address),
        .instr_waitrequest(instr_waitrequest_a), .instr_rvalid(instr_rvalid_a),
        .instr_readdata(instr_readdata_a),
        .data_read(data_read), .data_write(data_write), .data_address(data_address),
        .data_writedata(data_writedata), .data_waitrequest(data_waitrequest_a),
        .data_rvalid(data_rvalid_a), .data_readdata(data_readdata_a),
        .mem_address(mem_address_a), .mem_read(mem_read_a), .mem_write(mem_write_a),
        .mem_writedata(mem_writedata_a), .mem_readdata(mem_readdata_a)
    );

    mips_mem_arbiter #(.READ_LATENCY(2)) dut_b (
        .clk(clk), .reset(reset), .clk_enable(clk_enable),
        .instr_req(instr_req), .instr_address(instr_address),
        .instr_waitrequest(instr_waitrequest_b), .instr_rvalid(instr_rvalid_b),
        .instr_readdata(instr_readdata_b),
        .data_read(data_read), .data_write(data_write), .data_address(data_address),
        .data_writedata(data_writedata), .data_waitrequest(data_waitrequest_b),
        .data_rvalid(data_rvalid_b), .data_readdata(data_readdata_b),
        .mem_address(mem_address_b), .mem_read(mem_read_b), .mem_write(mem_write_b),
        .mem_writedata(mem_writedata_b), .mem_readdata(mem_readdata_b)
    );

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'hBFC0_0000) return 32'h2484_0003;
        return a ^ 32'h5A5A_0000;
    endfunction

    // Memory a answers one cycle after the issue edge; memory b shows garbage for one
    // cycle, then the word, so an early capture in the L=2 instance is visible.
    always @(posedge clk) begin
        if (mem_read_a) mem_readdata_a <= mem_fn(mem_address_a);
        if (mem_read_b) begin
            mem_readdata_b <= 32'hDEAD_BEEF;
            pend_data_b    <= mem_fn(mem_address_b);
            pend_b         <= 1'b1;
        end else if (pend_b) begin
            mem_readdata_b <= pend_data_b;
            pend_b         <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic do_reset();
        instr_req  = 1'b0;
        data_read  = 1'b0;
        data_write = 1'b0;
        clk_enable = 1'b1;
        reset      = 1'b0;
        step();
        reset = 1'b1;
    endtask

    initial begin
        // Test 1: reset held with both ports requesting
        instr_req     = 1'b1;
        instr_address = 32'h0000_1000;
        data_read     = 1'b1;
        data_write    = 1'b1;
        data_address  = 32'h0000_2000;
        data_writedata = 32'h1234_5678;
        step();
        settle();
        check("rst_instr_wait", 32'(instr_waitrequest_a), 32'd1);
        check("rst_data_wait", 32'(data_waitrequest_a), 32'd1);
        check("rst_mem_read", 32'(mem_read_a), 32'd0);
        check("rst_mem_write", 32'(mem_write_a), 32'd0);
        check("rst_mem_addr", mem_address_a, 32'h0);
        check("rst_mem_wdata", mem_writedata_a, 32'h0);
        check("rst_rvalid", {30'd0, instr_rvalid_a, data_rvalid_a}, 32'd0);
        check("rst_readdata", instr_readdata_a | data_readdata_a, 32'h0);

        // Test 2: single fetch, L=1
        do_reset();
        instr_req     = 1'b1;
        instr_address = 32'hBFC0_0000;
        settle();
        check("t2_c0_mem_read", 32'(mem_read_a), 32'd1);
        check("t2_c0_addr", mem_address_a, 32'hBFC0_0000);
        check("t2_c0_instr_wait", 32'(instr_waitrequest_a), 32'd0);
        step();
        instr_req = 1'b0;
        settle();
        check("t2_c1_rvalid", 32'(instr_rvalid_a), 32'd0);
        check("t2_c1_mem_read", 32'(mem_read_a), 32'd0);
        step();
        settle();
        check("t2_c2_rvalid", 32'(instr_rvalid_a), 32'd1);
        check("t2_c2_rdata", instr_readdata_a, 32'h2484_0003);
        step();
        settle();
        check("t2_c3_rvalid", 32'(instr_rvalid_a), 32'd0);
        check("t2_c3_rdata_held", instr_readdata_a, 32'h2484_0003);

        // Test 3: contention alternates, data first after reset
        do_reset();
        data_write     = 1'b1;
        data_address   = 32'h0000_0010;
        data_writedata = 32'd7;
        instr_req      = 1'b1;
        instr_address  = 32'h0000_0100;
        settle();
        check("t3_c0_mem_write", 32'(mem_write_a), 32'd1);
        check("t3_c0_addr", mem_address_a, 32'h0000_0010);
        check("t3_c0_wdata", mem_writedata_a, 32'd7);
        check("t3_c0_waits", {30'd0, instr_waitrequest_a, data_waitrequest_a}, 32'd2);
        step();
        settle();
        check("t3_c1_mem_read", 32'(mem_read_a), 32'd1);
        check("t3_c1_addr", mem_address_a, 32'h0000_0100);
        check("t3_c1_waits", {30'd0, instr_waitrequest_a, data_waitrequest_a}, 32'd1);
        step();
        settle();
        check("t3_c2_waits", {30'd0, instr_waitrequest_a, data_waitrequest_a}, 32'd3);
        step();
        settle();
        check("t3_c3_rvalid", 32'(instr_rvalid_a), 32'd1);
        check("t3_c3_rdata", instr_readdata_a, 32'h5A5A_0100);
        check("t3_c3_data_win", 32'(mem_write_a), 32'd1);
        step();
        settle();
        check("t3_c4_instr_win", {30'd0, instr_waitrequest_a, mem_read_a}, 32'd1);
        step();
        instr_req = 1'b0;
        settle();
        check("t3_c5_data_wait", 32'(data_waitrequest_a), 32'd1);
        step();
        data_writedata = 32'd8;
        settle();
        check("t3_c6_wdata", {mem_writedata_a[30:0], mem_write_a}, {31'd8, 1'b1});
        step();
        data_writedata = 32'd9;
        settle();
        check("t3_c7_wdata", {mem_writedata_a[30:0], mem_write_a}, {31'd9, 1'b1});
        step();
        data_write = 1'b0;

        // Test 4: back-to-back data reads, L=2
        do_reset();
        data_read    = 1'b1;
        data_address = 32'h0000_0020;
        settle();
        check("t4_c0_issue", {mem_address_b[30:0], mem_read_b}, {31'h20, 1'b1});
        check("t4_c0_wait", 32'(data_waitrequest_b), 32'd0);
        step();
        data_address = 32'h0000_0024;
        settle();
        check("t4_c1_wait", 32'(data_waitrequest_b), 32'd1);
        step();
        settle();
        check("t4_c2_rvalid", 32'(data_rvalid_b), 32'd0);
        check("t4_c2_mem_read", 32'(mem_read_b), 32'd0);
        step();
        settle();
        check("t4_c3_rvalid", 32'(data_rvalid_b), 32'd1);
        check("t4_c3_rdata", data_readdata_b, 32'h5A5A_0020);
        check("t4_c3_issue", {mem_address_b[30:0], mem_read_b}, {31'h24, 1'b1});
        check("t4_c3_wait", 32'(data_waitrequest_b), 32'd0);
        step();
        data_read = 1'b0;
        settle();
        check("t4_c4_rvalid", 32'(data_rvalid_b), 32'd0);
        step();
        settle();
        check("t4_c5_rvalid", 32'(data_rvalid_b), 32'd0);
        step();
        settle();
        check("t4_c6_rvalid", 32'(data_rvalid_b), 32'd1);
        check("t4_c6_rdata", data_readdata_b, 32'h5A5A_0024);

        // Test 5: reset pulse aborts an outstanding read
        do_reset();
        data_read    = 1'b1;
        data_address = 32'h0000_0030;
        settle();
        check("t5_c0_issue", 32'(mem_read_a), 32'd1);
        step();
        data_read = 1'b0;
        settle();
        reset = 1'b0;
        settle();
        check("t5_rst_waits", {30'd0, instr_waitrequest_a, data_waitrequest_a}, 32'd3);
        step();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("t5_no_rvalid", {30'd0, instr_rvalid_a, data_rvalid_a}, 32'd0);
            step();
        end
        check("t5_rdata_cleared", data_readdata_a, 32'h0);
        instr_req     = 1'b1;
        instr_address = 32'h0000_0040;
        settle();
        check("t5_grant", {mem_address_a[30:0], mem_read_a}, {31'h40, 1'b1});
        check("t5_grant_wait", 32'(instr_waitrequest_a), 32'd0);
        step();
        instr_req = 1'b0;
        step();
        settle();
        check("t5_rvalid", 32'(instr_rvalid_a), 32'd1);
        check("t5_rdata", instr_readdata_a, 32'h5A5A_0040);

        // Test 6: clk_enable low for three cycles inside RD_WAIT, L=1
        do_reset();
        data_read    = 1'b1;
        data_address = 32'h0000_0050;
        settle();
        check("t6_c0_issue", 32'(mem_read_a), 32'd1);
        step();
        data_read  = 1'b0;
        clk_enable = 1'b0;
        settle();
        check("t6_c1_wait", 32'(data_waitrequest_a), 32'd1);
        step();
        instr_req     = 1'b1;
        instr_address = 32'h0000_0060;
        settle();
        check("t6_c2_frozen", {30'd0, instr_waitrequest_a, mem_read_a}, 32'd2);
        step();
        instr_req = 1'b0;
        settle();
        check("t6_c3_rvalid", 32'(data_rvalid_a), 32'd0);
        step();
        clk_enable = 1'b1;
        settle();
        check("t6_c4_rvalid", 32'(data_rvalid_a), 32'd0);
        step();
        settle();
        check("t6_c5_rvalid", 32'(data_rvalid_a), 32'd1);
        check("t6_c5_rdata", data_readdata_a, 32'h5A5A_0050);
        step();
        settle();
        check("t6_c6_rvalid", 32'(data_rvalid_a), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
